// File: rtl/cnt_display_pkg.sv
// Shared types and constants for the counter display path: conversion FSM
// states, blank pattern and the active-low 7-segment decode.
package cnt_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int         DIGITS    = 3;

  // Active-low gfedcba; codes above 9 cannot come out of the converter and show blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter. Reconverts whenever the input
// differs from the last committed value; input changes mid-conversion are ignored.
module bin2bcd_seq
  import cnt_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        busy
);

  conv_state_t state, state_nx;
  logic [19:0] sh, sh_adj;
  logic [2:0]  iter;
  logic [7:0]  last_val, load_val;

  // Add 3 to every BCD nibble that would overflow past 9 after the shift.
  always_comb begin
    sh_adj = sh;
    for (int i = 0; i < DIGITS; i++)
      if (sh[8+4*i +: 4] >= 4'd5)
        sh_adj[8+4*i +: 4] = sh[8+4*i +: 4] + 4'd3;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (bin != last_val) state_nx = ST_SHIFT;
      ST_SHIFT:  if (iter == 3'd7) state_nx = ST_COMMIT;
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh       <= '0;
      iter     <= '0;
      last_val <= '0;
      load_val <= '0;
      bcd      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bin != last_val) begin
          sh       <= {12'b0, bin};
          iter     <= '0;
          load_val <= bin;
        end
        ST_SHIFT: begin
          sh   <= {sh_adj[18:0], 1'b0};
          iter <= iter + 3'd1;
        end
        ST_COMMIT: begin
          bcd      <= sh[19:8];
          last_val <= load_val;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: rtl/cnt_display.sv
// Three-digit multiplexed common-anode display of the seconds counter, with
// leading-zero blanking and registered segment/anode drive.
module cnt_display
  import cnt_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cnt,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]               presc;
  logic [1:0]                  idx;
  logic                        wrap;
  logic [DIGITS-1:0][3:0]      nib;
  logic [DIGITS-1:0]           blank;
  logic [DIGITS-1:0][6:0]      dig_seg;
  logic [6:0]                  seg_nx;
  logic [2:0]                  an_nx;

  bin2bcd_seq u_conv (
    .clk  (clk),
    .rst  (rst),
    .bin  (cnt),
    .bcd  (bcd),
    .busy (busy)
  );

  assign wrap = (presc == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= wrap ? '0 : presc + 1'b1;
      if (wrap) idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

  assign nib   = bcd;
  assign blank = {nib[2] == 4'd0, (nib[2] == 4'd0) && (nib[1] == 4'd0), 1'b0};

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign dig_seg[i] = blank[i] ? SEG_BLANK : seg_decode(nib[i]);
  end

  always_comb begin
    seg_nx = SEG_BLANK;
    an_nx  = 3'b111;
    case (idx)
      2'd0: begin seg_nx = dig_seg[0]; an_nx = 3'b110; end
      2'd1: begin seg_nx = dig_seg[1]; an_nx = 3'b101; end
      2'd2: begin seg_nx = dig_seg[2]; an_nx = 3'b011; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= 3'b111;
    end else begin
      seg <= seg_nx;
      an  <= an_nx;
    end
  end

endmodule

// File: tb/tb_cnt_display.sv
// Directed bench for cnt_display with SCAN_DIV=4: table of values with expected
// BCD and per-slot segments, plus latency, reset and scan sequences.
module tb_cnt_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cnt;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic [11:0] bcd;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  cnt_display #(.SCAN_DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .seg  (seg),
    .an   (an),
    .bcd  (bcd),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  val;
    logic [11:0] exp_bcd;
    logic [6:0]  seg_u;
    logic [6:0]  seg_t;
    logic [6:0]  seg_h;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for the slot with anode pattern a, then check its segments.
  task automatic chk_slot(input string name, input logic [2:0] a, input logic [6:0] s);
    int k;
    k = 0;
    while (an !== a && k < 16) begin tick(); k++; end
    if (an !== a) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout waiting an=%b, an=%b", name, a, an);
    end else chk(name, {25'd0, seg}, {25'd0, s});
  endtask

  initial begin
    vecs[0] = '{8'd255, 12'h255, 7'h12, 7'h12, 7'h24};
    vecs[1] = '{8'd7,   12'h007, 7'h78, 7'h7F, 7'h7F};
    vecs[2] = '{8'd40,  12'h040, 7'h40, 7'h19, 7'h7F};
    vecs[3] = '{8'd100, 12'h100, 7'h40, 7'h40, 7'h79};
    vecs[4] = '{8'd123, 12'h123, 7'h30, 7'h24, 7'h79};
    vecs[5] = '{8'd0,   12'h000, 7'h40, 7'h7F, 7'h7F};

    // Reset
    rst = 1'b1; cnt = 8'd0;
    repeat (3) tick();
    chk("rst_seg",  {25'd0, seg}, 32'h7F);
    chk("rst_an",   {29'd0, an},  32'h7);
    chk("rst_bcd",  {20'd0, bcd}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    tick();
    chk("rel_an_first", {29'd0, an}, 32'h6);
    chk("rel_busy",     {31'd0, busy}, 32'h0);
    chk_slot("rel_units", 3'b110, 7'h40);
    chk_slot("rel_tens",  3'b101, 7'h7F);
    chk_slot("rel_hund",  3'b011, 7'h7F);
    chk("rel_busy2", {31'd0, busy}, 32'h0);

    // Latency: 255 applied before E0
    cnt = 8'd255;
    for (int e = 0; e <= 8; e++) begin
      tick();
      chk($sformatf("lat_busy_E%0d", e), {31'd0, busy}, 32'h1);
      chk($sformatf("lat_bcd_E%0d", e), {20'd0, bcd}, 32'h0);
    end
    tick();
    chk("lat_busy_E9", {31'd0, busy}, 32'h0);
    chk("lat_bcd_E9",  {20'd0, bcd}, 32'h255);

    // Table of values
    for (int v = 0; v < 6; v++) begin
      cnt = vecs[v].val;
      repeat (11) tick();
      chk($sformatf("v%0d_bcd", v),  {20'd0, bcd}, {20'd0, vecs[v].exp_bcd});
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'h0);
      chk_slot($sformatf("v%0d_units", v), 3'b110, vecs[v].seg_u);
      chk_slot($sformatf("v%0d_tens", v),  3'b101, vecs[v].seg_t);
      chk_slot($sformatf("v%0d_hund", v),  3'b011, vecs[v].seg_h);
    end

    // Change during conversion: 100 at E0, 101 at E3, 102 at E5
    cnt = 8'd100;
    tick(); tick(); tick();        // E0..E2
    cnt = 8'd101;
    tick(); tick();                // E3, E4
    cnt = 8'd102;
    repeat (4) tick();             // E5..E8
    chk("chg_bcd_E8", {20'd0, bcd}, 32'h0);
    tick();                        // E9
    chk("chg_bcd_E9",  {20'd0, bcd}, 32'h100);
    chk("chg_busy_E9", {31'd0, busy}, 32'h0);
    tick();                        // E10
    chk("chg_busy_E10", {31'd0, busy}, 32'h1);
    repeat (8) tick();             // E18
    chk("chg_bcd_E18", {20'd0, bcd}, 32'h100);
    tick();                        // E19
    chk("chg_bcd_E19", {20'd0, bcd}, 32'h102);

    // Reset mid-conversion: 199 at E0, rst at E4
    tick();
    cnt = 8'd199;
    repeat (4) tick();             // E0..E3
    chk("rmid_busy_E3", {31'd0, busy}, 32'h1);
    rst = 1'b1;
    tick();                        // E4
    chk("rmid_busy_E4", {31'd0, busy}, 32'h0);
    chk("rmid_bcd_E4",  {20'd0, bcd}, 32'h0);
    chk("rmid_seg_E4",  {25'd0, seg}, 32'h7F);
    chk("rmid_an_E4",   {29'd0, an},  32'h7);
    rst = 1'b0;
    tick();                        // first IDLE edge: load
    chk("rmid_busy_load", {31'd0, busy}, 32'h1);
    repeat (8) tick();
    chk("rmid_bcd_E8", {20'd0, bcd}, 32'h0);
    tick();
    chk("rmid_bcd_E9", {20'd0, bcd}, 32'h199);

    // Scan sequence with 123
    cnt = 8'd123;
    repeat (11) tick();
    chk("scan_bcd", {20'd0, bcd}, 32'h123);
    begin
      int k;
      k = 0;
      while (an === 3'b110 && k < 16) begin tick(); k++; end
      k = 0;
      while (an !== 3'b110 && k < 16) begin tick(); k++; end
      for (int c = 0; c < 12; c++) begin
        logic [2:0] ea;
        logic [6:0] es;
        ea = (c < 4) ? 3'b110 : (c < 8) ? 3'b101 : 3'b011;
        es = (c < 4) ? 7'h30  : (c < 8) ? 7'h24  : 7'h79;
        chk($sformatf("scan_c%0d", c), {22'd0, an, seg}, {22'd0, ea, es});
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
